// File: rtl/guess_datapath.sv
// Guessing-game datapath: secret counter, guess sync/compare,
// result LEDs, attempt counter and enter-key debouncer.
module guess_datapath #(
  parameter int WIDTH           = 8,
  parameter int LIMIT           = 255,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ATT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_key_n,
  input  logic [WIDTH-1:0] i_guess,
  input  logic             i_inc_actual,
  input  logic             i_update_leds,
  output logic             o_enter,
  output logic             o_over,
  output logic             o_under,
  output logic             o_equal,
  output logic             o_led_over,
  output logic             o_led_under,
  output logic             o_led_equal,
  output logic [WIDTH-1:0] o_actual,
  output logic [ATT_W-1:0] o_attempts
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
  localparam logic [ATT_W-1:0] ATT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TOP =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE,
    COUNTING
  } db_state_t;

  logic [WIDTH-1:0] actual;
  logic [WIDTH-1:0] g_meta;
  logic [WIDTH-1:0] g_sync;
  logic [ATT_W-1:0] attempts;
  logic             k_meta;
  logic             k_sync;
  logic             k;
  logic             enter_q;
  logic             enter_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  db_state_t        state_q;
  db_state_t        state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      actual <= '0;
    end else if (i_inc_actual) begin
      actual <= (actual == LIM) ? '0 : actual + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_meta <= '0;
      g_sync <= '0;
    end else begin
      g_meta <= i_guess;
      g_sync <= g_meta;
    end
  end

  assign o_over  = (g_sync > actual);
  assign o_under = (g_sync < actual);
  assign o_equal = (g_sync == actual);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_led_over  <= 1'b0;
      o_led_under <= 1'b0;
      o_led_equal <= 1'b0;
    end else if (i_update_leds) begin
      o_led_over  <= o_over;
      o_led_under <= o_under;
      o_led_equal <= o_equal;
    end
  end

  // A new secret starts a fresh round, so clearing wins over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attempts <= '0;
    end else if (i_inc_actual) begin
      attempts <= '0;
    end else if (i_update_leds && attempts != ATT_MAX) begin
      attempts <= attempts + 1'b1;
    end
  end

  // Key sync stages idle at 1 so a reset looks like a released button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_meta <= 1'b1;
      k_sync <= 1'b1;
    end else begin
      k_meta <= i_key_n;
      k_sync <= k_meta;
    end
  end

  assign k = ~k_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enter_q <= enter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter_d = enter_q;
    unique case (state_q)
      STABLE: begin
        if (k != enter_q) begin
          state_d = COUNTING;
          cnt_d   = CNT_W'(1);
        end
      end
      COUNTING: begin
        if (k == enter_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TOP) begin
          enter_d = ~enter_q;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_enter    = enter_q;
  assign o_actual   = actual;
  assign o_attempts = attempts;

endmodule

// File: tb/tb_guess_datapath.sv
// Directed bench for guess_datapath: reset, wrap, compare,
// debounce, saturation/priority and async reset.
module tb_guess_datapath;

  logic       clk;
  logic       reset;
  logic       key_n;
  logic [7:0] guess;
  logic       inc;
  logic       upd;
  logic       inc_w;

  logic       enter, over, under, equal;
  logic       led_o, led_u, led_e;
  logic [7:0] actual;
  logic [3:0] att;

  logic       w_enter, w_over, w_under, w_equal;
  logic       w_led_o, w_led_u, w_led_e;
  logic [7:0] w_actual;
  logic [3:0] w_att;

  int n_checks;
  int n_errors;

  guess_datapath dut (
    .clk(clk), .reset(reset), .i_key_n(key_n),
    .i_guess(guess), .i_inc_actual(inc),
    .i_update_leds(upd), .o_enter(enter),
    .o_over(over), .o_under(under), .o_equal(equal),
    .o_led_over(led_o), .o_led_under(led_u),
    .o_led_equal(led_e), .o_actual(actual),
    .o_attempts(att)
  );

  guess_datapath #(.LIMIT(5)) dut_w (
    .clk(clk), .reset(reset), .i_key_n(key_n),
    .i_guess(guess), .i_inc_actual(inc_w),
    .i_update_leds(1'b0), .o_enter(w_enter),
    .o_over(w_over), .o_under(w_under),
    .o_equal(w_equal), .o_led_over(w_led_o),
    .o_led_under(w_led_u), .o_led_equal(w_led_e),
    .o_actual(w_actual), .o_attempts(w_att)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int  wexp [7] = '{1, 2, 3, 4, 5, 0, 1};
  logic seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    key_n = 1'b1;
    guess = 8'd0;
    inc   = 1'b0;
    upd   = 1'b0;
    inc_w = 1'b0;
    #12;
    check("rst_actual", actual, 0);
    check("rst_enter", enter, 0);
    check("rst_leds", {led_o, led_u, led_e}, 3'b000);
    check("rst_att", att, 0);
    check("rst_flags", {over, under, equal}, 3'b001);
    reset = 1'b0;
    step(1);

    // wrap with LIMIT=5
    inc_w = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check($sformatf("wrap%0d", i), w_actual, wexp[i]);
    end
    inc_w = 1'b0;
    check("wrap_att", w_att, 0);

    // compare
    inc = 1'b1;
    step(37);
    inc = 1'b0;
    check("act37", actual, 37);
    guess = 8'd50;
    step(1);
    check("lat1_over", over, 0);
    step(1);
    check("lat2_flags", {over, under, equal}, 3'b100);
    upd = 1'b1;
    step(1);
    upd = 1'b0;
    check("led_over", {led_o, led_u, led_e}, 3'b100);
    check("att1", att, 1);
    guess = 8'd37;
    step(2);
    check("eq_flags", {over, under, equal}, 3'b001);
    upd = 1'b1;
    step(1);
    upd = 1'b0;
    check("led_equal", {led_o, led_u, led_e}, 3'b001);
    check("att2", att, 2);
    guess = 8'd10;
    step(2);
    check("under_flags", {over, under, equal}, 3'b010);

    // debounce: 10 low, 3 high, then held low
    seen = 1'b0;
    key_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen |= enter;
    end
    key_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      seen |= enter;
    end
    key_n = 1'b0;
    for (int i = 1; i < 18; i++) begin
      step(1);
      seen |= enter;
    end
    check("db_no_early", seen, 0);
    step(1);
    check("db_rise18", enter, 1);
    step(12);
    check("db_hold", enter, 1);

    // saturation, then inc+update priority
    upd = 1'b1;
    step(20);
    upd = 1'b0;
    check("att_sat", att, 15);
    check("led_under", {led_o, led_u, led_e}, 3'b010);
    guess = 8'd100;
    step(2);
    inc = 1'b1;
    upd = 1'b1;
    step(1);
    inc = 1'b0;
    upd = 1'b0;
    check("prio_att", att, 0);
    check("prio_act", actual, 38);
    check("prio_leds", {led_o, led_u, led_e}, 3'b100);

    // async reset mid-debounce at actual=200
    inc = 1'b1;
    step(162);
    inc = 1'b0;
    check("act200", actual, 200);
    key_n = 1'b1;
    step(11);
    check("pre_rst_enter", enter, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_actual", actual, 0);
    check("arst_enter", enter, 0);
    check("arst_leds", {led_o, led_u, led_e}, 3'b000);
    check("arst_flags", {over, under, equal}, 3'b001);
    key_n = 1'b0;
    #10;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 1; i < 18; i++) begin
      step(1);
      seen |= enter;
    end
    check("held_no_early", seen, 0);
    step(1);
    check("held_rise18", enter, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
